// File: rtl/regmap_bank_rw_pkg.sv
// Shared definitions for the regmap channel register bank.
//   status_addr() : word address of the STATUS register (one past the last channel)
//   acc_t         : access type decoded from the bus write-enable
//   ch_lsb()      : LSB position of a channel inside the packed analog buses
package regmap_pkg;

    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } acc_t;

    // STATUS sits directly after the last channel register.
    function automatic int status_addr(input int num_ch);
        return num_ch;
    endfunction

    // Channel k occupies bits [k*width +: width] of the packed analog buses.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/regmap_bank_rw_if.sv
// SRAM-style regmap bus between the bus master and the channel register bank.
//   req     : access request, at most one per cycle
//   we      : 1 = write, 0 = read (qualified by req)
//   addr    : word address
//   wr_data : write data
//   rd_data : read data, valid with ack
//   ack     : one-cycle response pulse
//   err     : unmapped access, valid with ack
interface regmap_bank_rw_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ack;
    logic                  err;

    modport master (
        output req, we, addr, wr_data,
        input  rd_data, ack, err
    );

    modport slave (
        input  req, we, addr, wr_data,
        output rd_data, ack, err
    );
endinterface

// File: rtl/regmap_bank_rw_sync_chain.sv
// regmap_sync_chain: plain flop-chain synchronizer for one analog readback word.
// Each bit is synchronized independently; the analog side keeps the word stable
// long enough that bus coherency across bits is not needed.
//   clk_i : clock
//   rst_i : synchronous active-high reset, clears every stage
//   d_i   : asynchronous input word
//   q_o   : last synchronizer stage (SYNC_STAGES cycles of latency)
module regmap_sync_chain #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/regmap_bank_rw.sv
// regmap_bank_rw: NUM_CH-channel register bank between the regmap bus and the
// analog macro. Each channel has a write register driving the analog side and a
// synchronized readback path. Requests are acked one cycle later; unmapped
// addresses return err with read data 0 and discard writes.
// Optional feature macro: CHG_DETECT_EN adds per-channel sticky change flags,
// a W1C STATUS register at address NUM_CH and a change interrupt.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   bus        : regmap bus (slave side)
//   ana_data_i : analog readback, ch k at [k*DATA_WIDTH +: DATA_WIDTH], asynchronous
//   ana_data_o : write registers towards the analog macro, same packing
//   ana_upd_o  : one-cycle pulse per channel written
//   irq_o      : change-detect interrupt (0 without CHG_DETECT_EN)
module regmap_bank_rw
    import regmap_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  NUM_CH      = 8,
    parameter int                  ADDR_WIDTH  = 4,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    regmap_bank_rw_if.slave              bus,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ana_data_i,
    output logic [NUM_CH*DATA_WIDTH-1:0] ana_data_o,
    output logic [NUM_CH-1:0]            ana_upd_o,
    output logic                         irq_o
);

    acc_t                  acc;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [NUM_CH-1:0]     ch_sel;
    logic                  status_hit;
    logic                  mapped;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [DATA_WIDTH-1:0] sync_q [NUM_CH];

    logic                  ack_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;

`ifdef CHG_DETECT_EN
    localparam int STATUS_ADDR = status_addr(NUM_CH);
    localparam int ARM_W       = $clog2(SYNC_STAGES + 2);

    logic [ARM_W-1:0]  arm_cnt_reg;
    logic [NUM_CH-1:0] flag_reg;
    logic [NUM_CH-1:0] flag_next;
    logic [NUM_CH-1:0] set_vec;
    logic [NUM_CH-1:0] clr_vec;
    logic              irq_reg;
`endif

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign acc     = bus.we ? ACC_WR : ACC_RD;
    assign wr_fire = bus.req && (acc == ACC_WR);
    assign rd_fire = bus.req && (acc == ACC_RD);

`ifdef CHG_DETECT_EN
    assign status_hit = (bus.addr == ADDR_WIDTH'(STATUS_ADDR));
`else
    assign status_hit = 1'b0;
`endif

    assign mapped = (|ch_sel) || status_hit;

    // ------------------------------------------------------------------
    // Per-channel datapath: synchronizer, write register, update pulse
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] wr_reg;
            logic                  upd_reg;

            assign ch_sel[gi] = (bus.addr == ADDR_WIDTH'(gi));

            regmap_sync_chain #(
                .DATA_WIDTH  (DATA_WIDTH),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (ana_data_i[ch_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .q_o   (sync_q[gi])
            );

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wr_reg  <= RST_VAL;
                    upd_reg <= 1'b0;
                end else begin
                    upd_reg <= wr_fire && ch_sel[gi];
                    if (wr_fire && ch_sel[gi]) begin
                        wr_reg <= bus.wr_data;
                    end
                end
            end

            assign ana_data_o[ch_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = wr_reg;
            assign ana_upd_o[gi] = upd_reg;

`ifdef CHG_DETECT_EN
            // prev_reg lags the synchronizer output by one cycle; any
            // difference is a change, ignored until the chain has refilled
            // after reset.
            logic [DATA_WIDTH-1:0] prev_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    prev_reg <= '0;
                end else begin
                    prev_reg <= sync_q[gi];
                end
            end

            assign set_vec[gi] = (arm_cnt_reg == '0) && (prev_reg != sync_q[gi]);
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux: channels and STATUS are one-hot by address; unmapped reads 0
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel[k]) begin
                rd_mux = sync_q[k];
            end
        end
`ifdef CHG_DETECT_EN
        if (status_hit) begin
            rd_mux[NUM_CH-1:0] = flag_reg;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Response pipeline: one-cycle ack; read data held between read acks
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_reg     <= 1'b0;
            err_reg     <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            ack_reg <= bus.req;
            err_reg <= bus.req && !mapped;
            if (rd_fire) begin
                rd_data_reg <= rd_mux;
            end
        end
    end

    assign bus.ack     = ack_reg;
    assign bus.err     = err_reg;
    assign bus.rd_data = rd_data_reg;

    // ------------------------------------------------------------------
    // Change detect
    // ------------------------------------------------------------------
`ifdef CHG_DETECT_EN
    assign clr_vec   = (wr_fire && status_hit) ? bus.wr_data[NUM_CH-1:0] : '0;
    // Set is ORed in after the clear so a change in the W1C cycle is kept.
    assign flag_next = (flag_reg & ~clr_vec) | set_vec;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            arm_cnt_reg <= ARM_W'(SYNC_STAGES + 1);
            flag_reg    <= '0;
            irq_reg     <= 1'b0;
        end else begin
            if (arm_cnt_reg != '0) begin
                arm_cnt_reg <= arm_cnt_reg - ARM_W'(1);
            end
            flag_reg <= flag_next;
            irq_reg  <= |flag_reg;
        end
    end

    assign irq_o = irq_reg;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_regmap_bank_rw.sv
// Testbench for regmap_bank_rw: scoreboard of expected responses pushed when a
// request is driven and compared when the ack is observed.
// Build with +define+CHG_DETECT_EN to exercise the change-detect feature.
module tb_regmap_bank_rw;
    localparam int          DW   = 16;
    localparam int          NCH  = 8;
    localparam int          AW   = 4;
    localparam int          SS   = 2;
    localparam logic [15:0] RSTV = 16'hA5A5;
`ifdef CHG_DETECT_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [15:0] rdata;
        logic        err;
        logic [7:0]  upd;
    } sb_item_t;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [NCH*DW-1:0]   ana_data_i;
    logic [NCH*DW-1:0]   ana_data_o;
    logic [NCH-1:0]      ana_upd_o;
    logic                irq_o;

    sb_item_t            sb[$];
    logic [15:0]         exp_ana [NCH];
    logic [15:0]         model_rd;
    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;

    regmap_bank_rw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    regmap_bank_rw #(
        .DATA_WIDTH  (DW),
        .NUM_CH      (NCH),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS),
        .RST_VAL     (RSTV)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .bus        (bus_if),
        .ana_data_i (ana_data_i),
        .ana_data_o (ana_data_o),
        .ana_upd_o  (ana_upd_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_ana();
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("ana_ch%0d", k), {16'h0, ana_data_o[k*DW +: DW]}, {16'h0, exp_ana[k]});
        end
    endtask

    // Drive one request for one cycle and record the expected response.
    task automatic drive(input bit w, input int a, input logic [15:0] d, input logic [15:0] exp_rd);
        sb_item_t it;
        bit       mapped;
        mapped = (a < NCH) || (CHG && a == NCH);
        bus_if.req     = 1'b1;
        bus_if.we      = w;
        bus_if.addr    = AW'(a);
        bus_if.wr_data = d;
        it.due   = cyc + 1;
        it.err   = !mapped;
        it.upd   = '0;
        if (w) begin
            if (a < NCH) begin
                it.upd[a]  = 1'b1;
                exp_ana[a] = d;
            end
        end else begin
            model_rd = mapped ? exp_rd : 16'h0;
        end
        it.rdata = model_rd;
        sb.push_back(it);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus_if.req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        sb_item_t it;
        if (sb.size() > 0 && sb[0].due == cyc && !bus_if.ack) begin
            check("ack", {31'h0, bus_if.ack}, 32'h1);
            void'(sb.pop_front());
        end else if (bus_if.ack) begin
            if (sb.size() == 0) begin
                check("ack_spurious", {31'h0, bus_if.ack}, 32'h0);
            end else begin
                it = sb.pop_front();
                $display("ack cycle=%0d rdata=%h err=%b upd=%h", cyc, bus_if.rd_data, bus_if.err, ana_upd_o);
                check("ack_time", cyc, it.due);
                check("rdata", {16'h0, bus_if.rd_data}, {16'h0, it.rdata});
                check("err", {31'h0, bus_if.err}, {31'h0, it.err});
                check("upd", {24'h0, ana_upd_o}, {24'h0, it.upd});
            end
        end else if (ana_upd_o != '0) begin
            check("upd_spurious", {24'h0, ana_upd_o}, 32'h0);
        end
    end

    initial begin
        rst_i          = 1'b1;
        bus_if.req     = 1'b0;
        bus_if.we      = 1'b0;
        bus_if.addr    = '0;
        bus_if.wr_data = '0;
        ana_data_i     = '0;
        model_rd       = 16'h0;
        for (int k = 0; k < NCH; k++) exp_ana[k] = RSTV;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check_ana();
        check("rst_ack", {31'h0, bus_if.ack}, 32'h0);
        check("rst_err", {31'h0, bus_if.err}, 32'h0);
        check("rst_upd", {24'h0, ana_upd_o}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check("rst_rdata", {16'h0, bus_if.rd_data}, 32'h0);
        rst_i = 1'b0;
        idle(5);

        // 2: write ch3
        drive(1'b1, 3, 16'h1234, 16'h0);
        idle(2);
        check_ana();

        // 3: readback ch5 after synchronizer latency; a write keeps rd_data
        ana_data_i[5*DW +: DW] = 16'hBEEF;
        idle(SS + 1);
        drive(1'b0, 5, 16'h0, 16'hBEEF);
        drive(1'b1, 0, 16'h0F0F, 16'h0);
        idle(2);

        // synchronizer latency: old, old, new
        ana_data_i[6*DW +: DW] = 16'h6666;
        drive(1'b0, 6, 16'h0, 16'h0000);
        drive(1'b0, 6, 16'h0, 16'h0000);
        drive(1'b0, 6, 16'h0, 16'h6666);
        idle(2);

        // 4: unmapped read and write back-to-back
        drive(1'b0, 15, 16'h0, 16'h0);
        drive(1'b1, 12, 16'hDEAD, 16'h0);
        idle(2);
        check_ana();

`ifdef CHG_DETECT_EN
        // clear flags raised by the earlier ch5/ch6 changes
        drive(1'b1, NCH, 16'hFFFF, 16'h0);
        idle(3);
        drive(1'b0, NCH, 16'h0, 16'h0000);
        idle(2);

        // 5: change on ch1, irq one cycle after the flag
        ana_data_i[1*DW +: DW] = 16'h5555;
        idle(3);
        check("irq_lag", {31'h0, irq_o}, 32'h0);
        idle(1);
        check("irq_set", {31'h0, irq_o}, 32'h1);
        drive(1'b0, NCH, 16'h0, 16'h0002);
        drive(1'b1, NCH, 16'h0002, 16'h0);
        idle(2);
        check("irq_clr", {31'h0, irq_o}, 32'h0);
        drive(1'b0, NCH, 16'h0, 16'h0000);
        idle(2);

        // 6: change and W1C in the same cycle, set wins
        ana_data_i[1*DW +: DW] = 16'hAAAA;
        idle(2);
        drive(1'b1, NCH, 16'h0002, 16'h0);
        idle(2);
        check("irq_setwins", {31'h0, irq_o}, 32'h1);
        drive(1'b0, NCH, 16'h0, 16'h0002);
        idle(2);
`else
        // STATUS address is unmapped without change detect
        drive(1'b0, NCH, 16'h0, 16'h0);
        drive(1'b1, NCH, 16'hFFFF, 16'h0);
        idle(2);
        check_ana();
`endif

        // reset mid-burst: request in the reset cycle gets no ack
        drive(1'b0, 5, 16'h0, 16'hBEEF);
        rst_i       = 1'b1;
        bus_if.req  = 1'b1;
        bus_if.we   = 1'b1;
        bus_if.addr = AW'(2);
        bus_if.wr_data = 16'h7777;
        @(posedge clk); #1;
        bus_if.req = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        for (int k = 0; k < NCH; k++) exp_ana[k] = RSTV;
        model_rd = 16'h0;
        idle(5);
        check_ana();
        check("post_rst_rdata", {16'h0, bus_if.rd_data}, 32'h0);
        check("post_rst_irq", {31'h0, irq_o}, 32'h0);
`ifdef CHG_DETECT_EN
        drive(1'b0, NCH, 16'h0, 16'h0000);
`endif
        drive(1'b0, 5, 16'h0, 16'hBEEF);
        idle(4);
        check("sb_empty", sb.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
